spi_master_seq: RTL
===================

Name: spi_master_seq

Overview:
- Master-side transaction sequencer for the SPI slave/RAM path, in the same clock domain; the slave uses clk as its serial clock.
- Converts host write/read requests into the two-frame SPI protocol: address frame, then data frame.
- Drives SS_n/MOSI, captures read data from MISO and returns it to the host with a single-cycle valid pulse.
- Sits between the system host logic and the SPI slave wrapper.

Parameters:
- GAP_CYCLES, 2, cycles SS_n is held high between frames and after a transaction (min 1).
- RD_WAIT, 2, cycles after the last MOSI bit of a read-data frame before MISO capture starts (min 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE; the request is accepted on the edge where req_valid && req_ready.
- req_rw  in  1  0 = write, 1 = read.
- req_addr  in  8  RAM address.
- req_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_rdata  out  8  read data; holds its value until the next read completes.
- busy  out  1  high from acceptance until return to IDLE.
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

Behaviour:
- Reset state: state = IDLE, SS_n = 1, MOSI = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0, req_ready = 1, bit counter = 0.
- Reset mid-transaction: SS_n rises immediately (asynchronous). The transaction is dropped and no rsp_valid is issued.
- Acceptance: req_rw, req_addr and req_wdata are latched. The frame list is built as follows:
  - Write: F0 = {2'b00, addr}, F1 = {2'b01, wdata}.
  - Read: F0 = {2'b10, addr}, F1 = {2'b11, 8'h00}.
- All outputs are registered. Each state below lasts one clock per listed cycle.
  - LEAD (1 cycle): SS_n = 0, MOSI = 0.
  - SEL (1 cycle): SS_n = 0, MOSI = frame[9], the slave's write/read select bit.
  - SHIFT (10 cycles): MOSI = frame[9] down to frame[0], MSB first; the bit counter runs 0..9.
  - For a read F1 only:
    - RWAIT (RD_WAIT cycles): MOSI = 0.
    - RCAP (8 cycles): MISO sampled on each rising edge into a shift register, MSB first.
  - GAP (GAP_CYCLES cycles): SS_n = 1, MOSI = 0.
- Transitions:
  - IDLE -> LEAD on acceptance.
  - LEAD -> SEL -> SHIFT.
  - SHIFT, at counter 9:
    - -> RWAIT if read F1 and RD_WAIT > 0;
    - -> RCAP if read F1 and RD_WAIT = 0;
    - -> GAP otherwise.
  - RWAIT -> RCAP.
  - RCAP, after the 8th sample -> GAP.
  - GAP end: if F0 was just sent -> LEAD for F1; else -> IDLE.
- Response: rsp_rdata is loaded and rsp_valid pulses for 1 cycle on the cycle after the 8th MISO sample (the first GAP cycle).
- Frame lengths:
  - SS_n is low for 12 cycles per write frame and per read address frame.
  - SS_n is low for 12 + RD_WAIT + 8 cycles for the read data frame.
- Total transaction length, acceptance edge to req_ready high:
  - Write: 2 × (12 + GAP_CYCLES) = 28 cycles at defaults.
  - Read: (12 + GAP) + (20 + RD_WAIT + GAP) = 38 cycles at defaults.
- Handshake rules:
  - Back-to-back requests: req_ready reasserts in IDLE, so a request held high is accepted on the first IDLE cycle. There is a minimum of 1 IDLE cycle between transactions.
  - req_valid outside IDLE is ignored.
  - Changes to the request inputs after acceptance have no effect.
- MISO is ignored outside RCAP.
- The bit counter is 4 bits and is cleared on every state entry. No wrap beyond 9 is possible.

Test Plan:
- Reset then idle: rst pulse, no requests -> SS_n = 1, MOSI = 0, req_ready = 1, busy = 0, rsp_valid never asserted.
- Write addr 0x3C data 0xA5: SS_n low 12 cycles with MOSI sequence 0, 0, then 00_0011_1100; GAP of 2; second frame 0, 0, then 01_1010_0101; req_ready high at cycle 28; no rsp_valid.
- Read addr 0x81 with a MISO model returning 0x5E: F0 MOSI sequence 0, 1, then 10_1000_0001. F1 MOSI sequence 0, 1, then 11_0000_0000. After RD_WAIT = 2, capture 8 bits. Required: rsp_valid for exactly 1 cycle with rsp_rdata = 0x5E, followed by req_ready at cycle 38.
- Back-to-back: req_valid held high with a write then a read -> the second request is accepted only after IDLE. SS_n stays high for at least GAP_CYCLES plus 1 cycle between transactions. The latched fields are unaffected by input changes mid-transaction.
- Reset mid-frame: assert rst during SHIFT of a read F1 -> SS_n = 1 asynchronously in the same cycle, no rsp_valid, and after release a new read completes correctly.
- RD_WAIT = 0, GAP_CYCLES = 1 build: read of 0xFF -> capture starts the cycle after the last MOSI bit and rsp_rdata = 0xFF. Total read time is (12 + 1) + (20 + 1) = 34 cycles.

Source files
------------

// File: rtl/spi_master_seq.sv
// Host-to-SPI transaction sequencer: each request becomes an address frame and a data frame.
// A read data frame is followed by an 8-bit MISO capture; the result goes back with a one-cycle pulse.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// LEAD  | SS_n low, MOSI 0
// SEL   | MOSI carries the write/read select bit (frame[9])
// SHIFT | frame[9:0] shifted out MSB first, counter 0..9
// RWAIT | read data frame only: turnaround before capture
// RCAP  | read data frame only: 8 MISO samples, MSB first
// GAP   | SS_n high between frames and after a transaction
module spi_master_seq #(
    parameter int GAP_CYCLES = 2,
    parameter int RD_WAIT    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_SEL, S_SHIFT, S_RWAIT, S_RCAP, S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] RWAIT_LAST = 4'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_f1;
    logic       r_rw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [6:0] r_shift;
    logic       r_ss_n;
    logic       r_mosi;
    logic       r_ready;
    logic       r_busy;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_rdata;
    logic [9:0] w_frame;
    logic       w_mosi_nxt;
    logic       w_accept;
    logic       w_cap_last;

    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_cap_last = (r_state == S_RCAP) && (r_cnt == 4'd7);

    // Frame is only consumed from SEL onward, when the latched fields and r_f1 are stable.
    always_comb begin
        w_frame = {2'b00, r_addr};
        if (r_rw) begin
            w_frame = r_f1 ? {2'b11, 8'h00} : {2'b10, r_addr};
        end else if (r_f1) begin
            w_frame = {2'b01, r_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 4'd1;
        w_mosi_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (req_valid) w_state_nxt = S_LEAD;
            end
            S_LEAD: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_SEL;
            end
            S_SEL: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == 4'd9) begin
                    w_cnt_nxt = 4'd0;
                    if (r_f1 && r_rw) w_state_nxt = (RD_WAIT > 0) ? S_RWAIT : S_RCAP;
                    else              w_state_nxt = S_GAP;
                end
            end
            S_RWAIT: begin
                if (r_cnt == RWAIT_LAST) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_RCAP;
                end
            end
            S_RCAP: begin
                if (r_cnt == 4'd7) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = r_f1 ? S_IDLE : S_LEAD;
                end
            end
            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_state_nxt == S_SEL)        w_mosi_nxt = w_frame[9];
        else if (w_state_nxt == S_SHIFT) w_mosi_nxt = w_frame[4'd9 - w_cnt_nxt];
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f1        <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_shift     <= 7'h00;
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
        end else begin
            if (w_accept) begin
                r_rw    <= req_rw;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_f1    <= 1'b0;
            end else if (r_state == S_GAP && w_state_nxt == S_LEAD) begin
                r_f1 <= 1'b1;
            end
            if (r_state == S_RCAP) r_shift <= {r_shift[5:0], MISO};
            r_rsp_valid <= w_cap_last;
            if (w_cap_last) r_rsp_rdata <= {r_shift, MISO};
            r_ss_n  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
            r_mosi  <= w_mosi_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule
